// File: rtl/approx_operand_pipe.sv
// Two-stage per-lane operand encoder for an approximate multiplier with a saturating approximation counter.
// Build option: define APPROX_LSB_COMP_EN to force the encoded operand lsb to 1 (truncation-error compensation).
module approx_operand_pipe #(
  parameter int LANES   = 4,
  parameter int MULT_DW = 4,
  parameter int A_BW    = 8,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*A_BW-1:0]         in_a,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*MULT_DW-1:0]      mult_a_in,
  output logic [LANES-1:0]              a_sign,
  output logic [LANES*$clog2(A_BW)-1:0] a_shamt,
  output logic [LANES-1:0]              a_zero,
  input  logic                          cnt_clr,
  output logic [CNT_W-1:0]              approx_cnt
);

  localparam int SH_W  = $clog2(A_BW);
  localparam int PC_W  = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + 1;

  logic s1_valid;
  logic s1_load;
  logic s2_load;

  logic [A_BW-1:0] uns_c  [LANES];
  logic [SH_W-1:0] lead_c [LANES];
  logic [LANES-1:0] sign_c;

  logic [A_BW-1:0] s1_uns  [LANES];
  logic [SH_W-1:0] s1_lead [LANES];
  logic [LANES-1:0] s1_sign;

  logic [LANES*MULT_DW-1:0] mult_c;
  logic [LANES*SH_W-1:0]    shamt_c;
  logic [LANES-1:0]         zero_c;
  logic [LANES-1:0]         osign_c;

  logic [PC_W-1:0]  pop;
  logic [SUM_W-1:0] cnt_sum;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;

  // Magnitude and leading-one index; the most negative value maps to 2^(A_BW-1).
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sign_c[i] = in_a[i*A_BW + A_BW - 1];
      uns_c[i]  = sign_c[i] ? (~in_a[i*A_BW +: A_BW] + A_BW'(1)) : in_a[i*A_BW +: A_BW];
      lead_c[i] = '0;
      for (int b = 1; b < A_BW; b++) begin
        if (uns_c[i][b]) lead_c[i] = SH_W'(b);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_uns[i]  <= '0;
        s1_lead[i] <= '0;
      end
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= sign_c;
        for (int i = 0; i < LANES; i++) begin
          s1_uns[i]  <= uns_c[i];
          s1_lead[i] <= lead_c[i];
        end
      end
    end
  end

  // Shifting uns right by shamt leaves exactly {1, uns[L-1:L-MULT_DW+1]} in the low MULT_DW bits.
  always_comb begin
    mult_c  = '0;
    shamt_c = '0;
    zero_c  = '0;
    osign_c = '0;
    for (int i = 0; i < LANES; i++) begin
      logic [SH_W-1:0] sh;
      logic [A_BW-1:0] shifted;
      sh      = '0;
      shifted = s1_uns[i];
      if (s1_lead[i] > SH_W'(MULT_DW - 1)) begin
        sh      = s1_lead[i] - SH_W'(MULT_DW - 1);
        shifted = s1_uns[i] >> sh;
`ifdef APPROX_LSB_COMP_EN
        shifted[0] = 1'b1;
`else
        shifted[0] = shifted[0];
`endif
      end
      mult_c[i*MULT_DW +: MULT_DW] = shifted[MULT_DW-1:0];
      shamt_c[i*SH_W +: SH_W]      = sh;
      zero_c[i]                    = (s1_uns[i] == '0);
      osign_c[i]                   = s1_sign[i] && (s1_uns[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      mult_a_in <= '0;
      a_shamt   <= '0;
      a_zero    <= '0;
      a_sign    <= '0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        mult_a_in <= mult_c;
        a_shamt   <= shamt_c;
        a_zero    <= zero_c;
        a_sign    <= osign_c;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      if (a_shamt[i*SH_W +: SH_W] != '0) pop = pop + PC_W'(1);
    end
    cnt_sum = {1'b0, approx_cnt} + SUM_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      approx_cnt <= '0;
    end else if (cnt_clr) begin
      approx_cnt <= '0;
    end else if (out_valid && out_ready) begin
      approx_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_approx_operand_pipe.sv
// Self-checking bench for approx_operand_pipe: directed vectors, back-pressure, saturation, reset, random traffic.
module tb_approx_operand_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] mult_a_in;
  logic [3:0]  a_sign;
  logic [11:0] a_shamt;
  logic [3:0]  a_zero;
  logic        cnt_clr = 1'b0;
  logic [15:0] approx_cnt;

  approx_operand_pipe #(.LANES(4), .MULT_DW(4), .A_BW(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .mult_a_in(mult_a_in), .a_sign(a_sign),
    .a_shamt(a_shamt), .a_zero(a_zero), .cnt_clr(cnt_clr), .approx_cnt(approx_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] a; int c;} ent_t;
  ent_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   cnt_exp = 0;
  int   n_out = 0;
  bit   last_in_fire = 1'b0;

  // Reference encoding from plain integer arithmetic on the operand value.
  function automatic void enc_lane(input logic [7:0] a, output logic [3:0] m, output logic [2:0] sh,
                                   output logic s, output logic z);
    int v, u, l;
    v = int'($signed(a));
    u = (v < 0) ? -v : v;
    l = 0;
    for (int b = 0; b < 8; b++) if (u >= (1 << b)) l = b;
    z  = (u == 0);
    s  = (v < 0);
    sh = 3'((l > 3) ? l - 3 : 0);
    if (l > 3) begin
      m = 4'((u / (1 << (l - 3))) % 16);
`ifdef APPROX_LSB_COMP_EN
      m = m | 4'd1;
`endif
    end else begin
      m = 4'(u);
    end
  endfunction

  function automatic void enc_vec(input logic [31:0] a, output logic [15:0] m, output logic [11:0] sh,
                                  output logic [3:0] s, output logic [3:0] z, output int napx);
    logic [3:0] lm;
    logic [2:0] lsh;
    logic       ls, lz;
    m = '0; sh = '0; s = '0; z = '0; napx = 0;
    for (int i = 0; i < 4; i++) begin
      enc_lane(a[i*8 +: 8], lm, lsh, ls, lz);
      m[i*4 +: 4]  = lm;
      sh[i*3 +: 3] = lsh;
      s[i] = ls;
      z[i] = lz;
      if (lsh != 0) napx++;
    end
  endfunction

  function automatic logic [31:0] rand_vec(input int n_apx);
    logic [31:0] r;
    int          mag;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      mag = (i < n_apx) ? $urandom_range(16, 127) : $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) mag = -mag;
      r[i*8 +: 8] = 8'(mag);
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_any();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 7))
        0:       r[i*8 +: 8] = 8'h00;
        1:       r[i*8 +: 8] = 8'h80;
        default: r[i*8 +: 8] = 8'($urandom);
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check against the model, account for transfers, advance.
  task automatic cycle(input bit v, input logic [31:0] a, input bit ordy, input bit clr);
    logic [15:0] m;
    logic [11:0] sh;
    logic [3:0]  s, z;
    int          napx;
    bit          ov_exp, ir_exp, ifire, ofire;
    in_valid = v; in_a = a; out_ready = ordy; cnt_clr = clr;
    #3;
    ov_exp = (q.size() >= 2) || (q.size() == 1 && cyc >= q[0].c + 2);
    ir_exp = (q.size() < 2) || ordy;
    chk("in_ready", 32'(in_ready), 32'(ir_exp));
    chk("out_valid", 32'(out_valid), 32'(ov_exp));
    chk("approx_cnt", 32'(approx_cnt), 32'(cnt_exp));
    napx = 0;
    if (ov_exp) begin
      enc_vec(q[0].a, m, sh, s, z, napx);
      chk("mult_a_in", 32'(mult_a_in), 32'(m));
      chk("a_shamt", 32'(a_shamt), 32'(sh));
      chk("a_sign", 32'(a_sign), 32'(s));
      chk("a_zero", 32'(a_zero), 32'(z));
    end
    ifire = v && in_ready;
    ofire = out_valid && ordy;
    if (ofire && q.size() > 0) begin
      void'(q.pop_front());
      n_out++;
    end
    if (clr) cnt_exp = 0;
    else if (ofire) cnt_exp = (cnt_exp + napx > 65535) ? 65535 : cnt_exp + napx;
    if (ifire) q.push_back('{a, cyc});
    last_in_fire = ifire;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int k = 0; k < 12 && q.size() > 0; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] vecs [8];
    int          idx, base, sent;
    bit          saw_block;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cnt", 32'(approx_cnt), 32'd0);
    chk("rst_mult", 32'(mult_a_in), 32'd0);
    chk("rst_shamt", 32'(a_shamt), 32'd0);
    chk("rst_flags", {24'd0, a_sign, a_zero}, 32'd0);
    rst_n = 1'b1;

    // lanes {100, -100, 5, 0}
    cycle(1'b1, 32'h00059C64, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("d1_valid", 32'(out_valid), 32'd1);
`ifdef APPROX_LSB_COMP_EN
    chk("d1_mult", 32'(mult_a_in), 32'h05DD);
`else
    chk("d1_mult", 32'(mult_a_in), 32'h05CC);
`endif
    chk("d1_shamt", 32'(a_shamt), 32'h01B);
    chk("d1_sign", 32'(a_sign), 32'h2);
    chk("d1_zero", 32'(a_zero), 32'h8);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("d1_cnt", 32'(approx_cnt), 32'd2);

    // lanes {-128, 15, 16, 127}
    cycle(1'b1, 32'h7F100F80, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("d2_valid", 32'(out_valid), 32'd1);
`ifdef APPROX_LSB_COMP_EN
    chk("d2_mult", 32'(mult_a_in), 32'hF9F9);
`else
    chk("d2_mult", 32'(mult_a_in), 32'hF8F8);
`endif
    chk("d2_shamt", 32'(a_shamt), 32'h644);
    chk("d2_sign", 32'(a_sign), 32'h1);
    chk("d2_zero", 32'(a_zero), 32'h0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("d2_cnt", 32'(approx_cnt), 32'd5);

    // 8 back-to-back vectors, consumer stalls in cycles 3..5
    for (int i = 0; i < 8; i++) vecs[i] = rand_any();
    idx = 0;
    base = n_out;
    saw_block = 1'b0;
    for (int k = 0; k < 40 && (idx < 8 || q.size() > 0); k++) begin
      if (k >= 3 && k <= 5 && in_ready === 1'b0) saw_block = 1'b1;
      cycle(idx < 8, (idx < 8) ? vecs[idx] : 32'h0, !(k >= 3 && k <= 5), 1'b0);
      if (last_in_fire) idx++;
    end
    chk("stream_accepted", 32'(idx), 32'd8);
    chk("stream_emerged", 32'(n_out - base), 32'd8);
    chk("stream_backpressure", 32'(saw_block), 32'd1);

    // counter preload to 65534, then saturate, then clear with a coincident transfer
    cycle(1'b0, '0, 1'b1, 1'b1);
    sent = 0;
    for (int k = 0; k < 20000 && sent < 16383; k++) begin
      cycle(1'b1, rand_vec(4), 1'b1, 1'b0);
      if (last_in_fire) sent++;
    end
    cycle(1'b1, rand_vec(2), 1'b1, 1'b0);
    drain();
    chk("preload_cnt", 32'(approx_cnt), 32'd65534);
    cycle(1'b1, rand_vec(4), 1'b1, 1'b0);
    drain();
    chk("sat_cnt", 32'(approx_cnt), 32'd65535);
    cycle(1'b1, rand_vec(4), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("clr_xfer_valid", 32'(out_valid), 32'd1);
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("clr_priority", 32'(approx_cnt), 32'd0);

    // reset with two vectors in flight
    cycle(1'b1, rand_vec(3), 1'b0, 1'b0);
    cycle(1'b1, rand_vec(4), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_mult", 32'(mult_a_in), 32'd0);
    chk("mid_rst_cnt", 32'(approx_cnt), 32'd0);
    q.delete();
    cnt_exp = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    base = n_out;
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("no_stale", 32'(n_out - base), 32'd0);

    // random traffic with random back-pressure and clears
    for (int k = 0; k < 400; k++)
      cycle($urandom_range(0, 9) < 7, rand_any(), $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_operand_pipe.md
APPROX_OPERAND_PIPE -- requirements
Module: approx_operand_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of independent operand lanes.
REQ-002 The block SHALL have parameter MULT_DW, default 4, giving the accurate-multiplier operand width; legal range is 3 <= MULT_DW < A_BW.
REQ-003 The block SHALL have parameter A_BW, default 8, giving the signed two's-complement operand width per lane.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the approximation-event counter width.
REQ-005 The block SHALL have port clk  input  1  as its single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst_n  input  1  as its reset, asynchronous and active-low.
REQ-007 The block SHALL have port in_valid  input  1  indicating that in_a holds an operand vector.
REQ-008 The block SHALL have port in_ready  output  1  indicating that the block accepts in_a this cycle.
REQ-009 The block SHALL have port in_a  input  LANES*A_BW  carrying the signed operands; lane i occupies bits [i*A_BW +: A_BW].
REQ-010 The block SHALL have port out_valid  output  1  indicating that the result outputs are valid.
REQ-011 The block SHALL have port out_ready  input  1  indicating that the consumer accepts the result this cycle.
REQ-012 The block SHALL have port mult_a_in  output  LANES*MULT_DW  carrying the multiplier operand per lane.
REQ-013 The block SHALL have port a_sign  output  LANES  carrying the operand sign per lane.
REQ-014 The block SHALL have port a_shamt  output  LANES*$clog2(A_BW)  carrying the post-multiply left-shift amount per lane.
REQ-015 The block SHALL have port a_zero  output  LANES  flagging a zero operand per lane.
REQ-016 The block SHALL have port cnt_clr  input  1  as a synchronous clear for approx_cnt.
REQ-017 The block SHALL have port approx_cnt  output  CNT_W  as a saturating count of lanes encoded with a_shamt != 0.

Function
REQ-018 Per lane, the block SHALL take uns = |a| in A_BW bits and sign = MSB of a; for -2^(A_BW-1), uns SHALL be 2^(A_BW-1).
REQ-019 Per lane, the block SHALL take L = index of the leading one of uns, with L = 0 when uns = 0.
REQ-020 When L > MULT_DW-1, the block SHALL output a_shamt = L-(MULT_DW-1) and mult_a_in = {1'b1, uns[L-1 : L-MULT_DW+2], lsb}, with lsb as defined under Configuration.
REQ-021 When L <= MULT_DW-1, the block SHALL output a_shamt = 0 and mult_a_in = uns[MULT_DW-1:0].
REQ-022 The block SHALL set a_zero to 1 exactly when uns = 0, and SHALL then drive mult_a_in = 0, a_shamt = 0 and a_sign = 0.
REQ-023 The block SHALL be a two-stage pipeline: S1 registers uns, sign and L; S2 registers the outputs.
REQ-024 Latency SHALL be 2 cycles from the accepting edge to out_valid when no stall occurs; throughput SHALL be 1 vector per cycle.
REQ-025 An input transfer SHALL occur on in_valid && in_ready, and an output transfer on out_valid && out_ready.
REQ-026 S2 SHALL load when !out_valid || out_ready.
REQ-027 S1 SHALL load when !S1.valid || S2 loads.
REQ-028 in_ready SHALL equal the S1 load condition and SHALL be purely combinational from internal state and out_ready.
REQ-029 While out_valid && !out_ready, all result outputs SHALL hold stable, and no vector SHALL be dropped or duplicated.
REQ-030 Simultaneous input and output transfers on a full pipeline SHALL sustain one transfer per cycle.
REQ-031 approx_cnt SHALL increase by the number of lanes with nonzero a_shamt on each output transfer.
REQ-032 approx_cnt SHALL saturate at 2^CNT_W-1.
REQ-033 cnt_clr SHALL take priority over counting, so the counter reads 0 on the next cycle even when an output transfer coincides.

Reset
REQ-034 When rst_n is asserted, the block SHALL immediately clear out_valid, both stage-valid flags, approx_cnt, mult_a_in, a_sign, a_shamt and a_zero to 0.
REQ-035 During reset, in_ready SHALL read 1 once rst_n is released.
REQ-036 Vectors in flight when reset is asserted mid-operation SHALL be discarded.

Configuration
REQ-037 When macro APPROX_LSB_COMP_EN is defined, the encoded operand lsb SHALL be a constant 1 (truncation-error compensation).
REQ-038 When APPROX_LSB_COMP_EN is undefined, lsb SHALL be uns[L-MULT_DW+1] (plain truncation).
REQ-039 REQ-021 and REQ-022 SHALL apply unchanged with or without APPROX_LSB_COMP_EN.

Verification (LANES=4, MULT_DW=4, A_BW=8, out_ready=1)
REQ-040 Bench SHALL drive in_a lanes {100, -100, 5, 0} -> two cycles later the block outputs mult {1101,1101,0101,0000} with COMP_EN (or {1100,1100,0101,0000} without), shamt {3,3,0,0}, sign {0,1,0,0}, zero {0,0,0,1}, and approx_cnt=2.
REQ-041 Bench SHALL drive lanes {-128, 15, 16, 127} -> mult {1001,1111,1001,1111} with COMP_EN (or {1000,1111,1000,1111} without), shamt {4,0,1,3}.
REQ-042 Bench SHALL stream 8 vectors back-to-back with out_ready low for cycles 3-5 -> in_ready=0 once both stages fill, outputs hold, and all 8 vectors emerge in order without loss.
REQ-043 Bench SHALL preload approx_cnt to 2^16-2 via traffic, then transfer a vector with 4 approximated lanes -> approx_cnt=65535; then assert cnt_clr together with a transfer -> approx_cnt=0.
REQ-044 Bench SHALL assert rst_n low for 1 cycle with 2 vectors in flight -> out_valid=0 immediately, in_ready=1 after release, and no stale vector appears.
